seg7_segment_monitor: RTL and testbench
=======================================

SEG7_SEGMENT_MONITOR -- requirements
Module: seg7_segment_monitor

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, the Wishbone base address; bits [3:0] are ignored.
REQ-002 SHALL have parameter STABLE_DEFAULT, default 16'd1000, the reset value of the stability threshold T.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port seg_in, input, 7 bits: segment lines sampled from the I/O pads; bit0=a through bit6=g, active-high.
REQ-006 SHALL have ports wbs_stb_i, wbs_cyc_i and wbs_we_i, inputs, 1 bit each: Wishbone request.
REQ-007 SHALL have ports wbs_sel_i (4 bits), wbs_adr_i (32 bits) and wbs_dat_i (32 bits), inputs: Wishbone byte selects, address and write data.
REQ-008 SHALL have ports wbs_ack_o (output, 1 bit) and wbs_dat_o (output, 32 bits): Wishbone acknowledge and read data.
REQ-009 SHALL have port irq, output, 1 bit: one-cycle pulse on each valid-digit commit.

Function
REQ-010 SHALL pass seg_in through a 2-flop synchronizer; its output s is the only copy of the pads used downstream.
REQ-011 SHALL hold s_prev, updated every cycle from s.
REQ-012 SHALL clear the stability count cnt to 0 when s != s_prev; otherwise cnt SHALL increment, saturating at T.
REQ-013 SHALL commit s when s == s_prev, cnt == T-1 and s != committed pattern.
REQ-014 SHALL treat a CTRL value of T=0 as T=1.
REQ-015 SHALL make a commit visible T+3 clocks after the first clk edge that samples the new seg_in value.
REQ-016 SHALL decode the 10 valid patterns 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F to digits 0-9; every other pattern is invalid.
REQ-017 SHALL, on a valid commit: load digit, set valid=1, increment COUNT (saturating at 0xFFFF), and pulse irq for exactly 1 cycle.
REQ-018 SHALL, on an invalid commit: set valid=0, hold digit, increment ERRCNT (saturating at 0xFFFF), and leave irq low.
REQ-019 SHALL map registers at word offsets of adr[3:2]:
- 0x0 STATUS, read-only: [3:0] digit, [4] valid, [14:8] committed pattern, other bits 0.
- 0x4 COUNT, [15:0]: any write clears it.
- 0x8 CTRL, [15:0] = T, read/write; honours wbs_sel_i[1:0] per byte.
- 0xC ERRCNT, [15:0]: any write clears it.
REQ-020 SHALL decode a request only when stb && cyc && adr[31:4] == BASE_ADDR[31:4]; non-matching requests SHALL get no ack.
REQ-021 SHALL assert wbs_ack_o for exactly 1 cycle, in the cycle after the request is decoded.
REQ-022 SHALL not decode a new request while wbs_ack_o is high.
REQ-023 SHALL register wbs_dat_o alongside ack and drive it to 0 when ack is low.
REQ-024 SHALL, when a clearing write and a commit increment land in the same cycle, apply the clear first, so the counter reads 1.
REQ-025 SHALL use a new CTRL value from the cycle after ack; a change of T SHALL NOT reset cnt.

Reset
REQ-026 SHALL, while reset_n is low, asynchronously force:
- synchronizer, s_prev and committed pattern to 0x00;
- cnt, digit, COUNT and ERRCNT to 0, and valid to 0;
- T to STABLE_DEFAULT;
- wbs_ack_o, wbs_dat_o and irq to 0.
REQ-027 SHALL, on reset assertion during a Wishbone cycle, abort the cycle without ack; on release, decoding resumes on the next clk edge.
REQ-028 SHALL, since the reset-state committed pattern is 0x00, produce no commit for a pads-blank input after reset.

Verification
REQ-029 SHALL cover: T=4, seg_in 0x00->0x5B held -> at clock 7: STATUS=0x5B12, COUNT=1, irq high for 1 cycle.
REQ-030 SHALL cover: T=4, seg_in 0x06 toggled every 3 cycles -> no commit, COUNT=0, irq never high.
REQ-031 SHALL cover: T=2, seg_in=0x49 held -> valid=0, ERRCNT=1, digit unchanged, no irq.
REQ-032 SHALL cover: write COUNT in the same cycle as a valid commit -> COUNT reads 1.
REQ-033 SHALL cover: read at BASE+0x8 after reset -> ack 1 cycle later with data 0x000003E8; read at BASE+0x10 -> no ack.
REQ-034 SHALL cover: reset_n pulsed low mid-stability count -> all outputs 0; a re-presented pattern needs a full T+3 clocks to commit.

Source files
------------

// File: rtl/seg7_segment_monitor.sv
// Seven-segment pad monitor: synchronises and debounces the segment lines, decodes
// each newly committed pattern to a digit and exposes status/counters on Wishbone.
module seg7_segment_monitor #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter logic [15:0] STABLE_DEFAULT = 16'd1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  seg_in,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq
);

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_ERRCNT = 2'd3;

  // Returns {valid, digit}; anything outside the ten digit shapes is invalid.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h3F:   res = {1'b1, 4'd0};
      7'h06:   res = {1'b1, 4'd1};
      7'h5B:   res = {1'b1, 4'd2};
      7'h4F:   res = {1'b1, 4'd3};
      7'h66:   res = {1'b1, 4'd4};
      7'h6D:   res = {1'b1, 4'd5};
      7'h7D:   res = {1'b1, 4'd6};
      7'h07:   res = {1'b1, 4'd7};
      7'h7F:   res = {1'b1, 4'd8};
      7'h6F:   res = {1'b1, 4'd9};
      default: res = {1'b0, 4'd0};
    endcase
    return res;
  endfunction

  logic [6:0]  sync1_q, sync1_d, sync2_q, sync2_d, s_prev_q, s_prev_d;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  pat_q, pat_d;
  logic [3:0]  digit_q, digit_d;
  logic        valid_q, valid_d;
  logic        irq_q, irq_d;
  logic [15:0] count_q, count_d, errcnt_q, errcnt_d, ctrl_q, ctrl_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        wr_q, wr_d;
  logic [1:0]  wreg_q, wreg_d;
  logic [1:0]  wsel_q, wsel_d;
  logic [15:0] wdat_q, wdat_d;

  logic [6:0]  s;
  logic        stable;
  logic [15:0] t_eff;
  logic        commit;
  logic [4:0]  dec;
  logic        addr_hit, req, wr_apply;
  logic [31:0] rd_data;
  logic [15:0] count_base, errcnt_base;
  logic        unused_bits;

  assign s        = sync2_q;
  assign stable   = (s == s_prev_q);
  assign t_eff    = (ctrl_q == 16'd0) ? 16'd1 : ctrl_q;
  assign commit   = stable && (cnt_q == (t_eff - 16'd1)) && (s != pat_q);
  assign dec      = seg_decode(s);
  assign addr_hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req      = wbs_stb_i && wbs_cyc_i && addr_hit && !ack_q;
  // The write is applied on the edge that closes the ack cycle.
  assign wr_apply = ack_q && wr_q;

  assign unused_bits = ^{wbs_sel_i[3:2], wbs_adr_i[1:0], wbs_dat_i[31:16]};

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = irq_q;

  always_comb begin
    sync1_d  = seg_in;
    sync2_d  = sync1_q;
    s_prev_d = sync2_q;
    cnt_d    = cnt_q;
    if (!stable) begin
      cnt_d = 16'd0;
    end else if (cnt_q >= t_eff) begin
      cnt_d = t_eff;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    pat_d   = pat_q;
    digit_d = digit_q;
    valid_d = valid_q;
    irq_d   = 1'b0;
    if (commit) begin
      pat_d   = s;
      valid_d = dec[4];
      if (dec[4]) begin
        digit_d = dec[3:0];
        irq_d   = 1'b1;
      end else begin
        digit_d = digit_q;
        irq_d   = 1'b0;
      end
    end else begin
      pat_d = pat_q;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (wbs_adr_i[3:2])
      REG_STATUS: rd_data = {17'd0, pat_q, 3'd0, valid_q, digit_q};
      REG_COUNT:  rd_data = {16'd0, count_q};
      REG_CTRL:   rd_data = {16'd0, ctrl_q};
      REG_ERRCNT: rd_data = {16'd0, errcnt_q};
      default:    rd_data = 32'd0;
    endcase
  end

  always_comb begin
    ack_d  = 1'b0;
    dat_d  = 32'd0;
    wr_d   = 1'b0;
    wreg_d = wreg_q;
    wsel_d = wsel_q;
    wdat_d = wdat_q;
    if (req) begin
      ack_d  = 1'b1;
      wr_d   = wbs_we_i;
      wreg_d = wbs_adr_i[3:2];
      wsel_d = wbs_sel_i[1:0];
      wdat_d = wbs_dat_i[15:0];
      if (wbs_we_i) begin
        dat_d = 32'd0;
      end else begin
        dat_d = rd_data;
      end
    end else begin
      ack_d = 1'b0;
    end
  end

  // A clearing write lands before a same-cycle commit increment.
  always_comb begin
    count_base  = count_q;
    errcnt_base = errcnt_q;
    ctrl_d      = ctrl_q;
    if (wr_apply && (wreg_q == REG_COUNT)) begin
      count_base = 16'd0;
    end else begin
      count_base = count_q;
    end
    if (wr_apply && (wreg_q == REG_ERRCNT)) begin
      errcnt_base = 16'd0;
    end else begin
      errcnt_base = errcnt_q;
    end
    if (wr_apply && (wreg_q == REG_CTRL)) begin
      if (wsel_q[0]) begin
        ctrl_d[7:0] = wdat_q[7:0];
      end else begin
        ctrl_d[7:0] = ctrl_q[7:0];
      end
      if (wsel_q[1]) begin
        ctrl_d[15:8] = wdat_q[15:8];
      end else begin
        ctrl_d[15:8] = ctrl_q[15:8];
      end
    end else begin
      ctrl_d = ctrl_q;
    end
    if (commit && dec[4] && (count_base != 16'hFFFF)) begin
      count_d = count_base + 16'd1;
    end else begin
      count_d = count_base;
    end
    if (commit && !dec[4] && (errcnt_base != 16'hFFFF)) begin
      errcnt_d = errcnt_base + 16'd1;
    end else begin
      errcnt_d = errcnt_base;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 7'h00;
      sync2_q  <= 7'h00;
      s_prev_q <= 7'h00;
      cnt_q    <= 16'd0;
      pat_q    <= 7'h00;
      digit_q  <= 4'd0;
      valid_q  <= 1'b0;
      irq_q    <= 1'b0;
      count_q  <= 16'd0;
      errcnt_q <= 16'd0;
      ctrl_q   <= STABLE_DEFAULT;
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
      wr_q     <= 1'b0;
      wreg_q   <= 2'd0;
      wsel_q   <= 2'd0;
      wdat_q   <= 16'd0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      s_prev_q <= s_prev_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      digit_q  <= digit_d;
      valid_q  <= valid_d;
      irq_q    <= irq_d;
      count_q  <= count_d;
      errcnt_q <= errcnt_d;
      ctrl_q   <= ctrl_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      wr_q     <= wr_d;
      wreg_q   <= wreg_d;
      wsel_q   <= wsel_d;
      wdat_q   <= wdat_d;
    end
  end

endmodule

// File: tb/tb_seg7_segment_monitor.sv
// Scoreboard bench for seg7_segment_monitor: bus reads push expected data that a
// negedge monitor pops on ack; irq pulses are logged with their clock-edge number.
module tb_seg7_segment_monitor;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  seg_in;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  logic [31:0] exp_q[$];
  bit          chk_q[$];
  string       nm_q[$];
  int          irq_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  seg7_segment_monitor dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .seg_in    (seg_in),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .irq       (irq)
  );

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic [31:0] e;
    bit c;
    string n;
    forever begin
      @(negedge clk);
      if (irq === 1'b1) irq_log.push_back(edge_n);
      if (ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: ack=1 data 0x%08h, expected no ack", rdat);
        end else begin
          e = exp_q.pop_front();
          c = chk_q.pop_front();
          n = nm_q.pop_front();
          if (c) check32(n, rdat, e);
        end
      end else begin
        check32("dat_idle", rdat, 32'd0);
      end
    end
  endtask

  // Called at a negedge; returns at a negedge one cycle after the transfer ends.
  task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit exp_ack, input bit chk,
                         input logic [31:0] exp, input string nm);
    int n = 0;
    bit got = 1'b0;
    if (exp_ack) begin
      exp_q.push_back(exp);
      chk_q.push_back(chk);
      nm_q.push_back(nm);
    end
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        got = 1'b1;
        n = i;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    checks++;
    if (exp_ack && !got) begin
      errors++;
      $display("FAIL %s_timeout: got no ack expected ack", nm);
      void'(exp_q.pop_back());
      void'(chk_q.pop_back());
      void'(nm_q.pop_back());
    end else if (!exp_ack && got) begin
      errors++;
      $display("FAIL %s_noack: got ack expected none", nm);
    end else if (exp_ack && n != 1) begin
      errors++;
      $display("FAIL %s_lat: got %0d cycles expected 1", nm, n);
    end
    @(negedge clk);
  endtask

  task automatic set_seg(input logic [6:0] v, output int e0);
    @(negedge clk);
    seg_in = v;
    e0 = edge_n + 1;
  endtask

  task automatic wait_edge(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic check_irq(input string nm, input int n_exp, input int edge_exp);
    checks++;
    if (irq_log.size() != n_exp) begin
      errors++;
      $display("FAIL %s_irqs: got %0d irq cycles expected %0d", nm, irq_log.size(), n_exp);
    end else if (n_exp > 0) begin
      checks++;
      if (irq_log[0] != edge_exp) begin
        errors++;
        $display("FAIL %s_irq_edge: got edge %0d expected %0d", nm, irq_log[0], edge_exp);
      end
    end
    irq_log.delete();
  endtask

  task automatic check_outs_zero(input string nm);
    check32({nm, "_ack"}, {31'd0, ack}, 32'd0);
    check32({nm, "_dat"}, rdat, 32'd0);
    check32({nm, "_irq"}, {31'd0, irq}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_outs_zero("rst_pulse");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int e0;
    int e1;
    reset_n = 1'b0; seg_in = 7'h00;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; wdat = 32'd0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check_outs_zero("rst_init");
    reset_n = 1'b1;

    // Reset defaults, address decode, blank pads produce nothing
    wb_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_03E8, "ctrl_rst");
    wb_xfer(1'b0, BASE + 32'h10, 32'd0, 4'hF, 1'b0, 1'b0, 32'd0, "off_range");
    wb_xfer(1'b0, 32'h3100_0008, 32'd0, 4'hF, 1'b0, 1'b0, 32'd0, "other_base");
    repeat (10) @(negedge clk);
    check_irq("blank", 0, 0);
    wb_xfer(1'b0, BASE, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_0000, "status_blank");

    // T=4, 0x00 -> 0x5B: commit on the 7th edge counting the first sampling edge
    wb_xfer(1'b1, BASE + 32'h8, 32'h0000_0004, 4'h3, 1'b1, 1'b0, 32'd0, "wr_t4");
    set_seg(7'h5B, e0);
    wait_edge(e0 + 14);
    check_irq("digit2", 1, e0 + 6);
    wb_xfer(1'b0, BASE, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_5B12, "status_5b");
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_0001, "count_1");
    wb_xfer(1'b0, BASE + 32'hC, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_0000, "errcnt_0");

    // COUNT clear applied on the same edge as a valid commit
    set_seg(7'h4F, e0);
    wait_edge(e0 + 4);
    wb_xfer(1'b1, BASE + 32'h4, 32'd0, 4'hF, 1'b1, 1'b0, 32'd0, "count_clr");
    wait_edge(e0 + 14);
    check_irq("digit3", 1, e0 + 6);
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_0001, "count_clr_race");
    wb_xfer(1'b0, BASE, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_4F13, "status_4f");

    // T written as 0 behaves as T=1
    wb_xfer(1'b1, BASE + 32'h8, 32'h0000_0000, 4'h3, 1'b1, 1'b0, 32'd0, "wr_t0");
    set_seg(7'h07, e0);
    wait_edge(e0 + 8);
    check_irq("t0", 1, e0 + 3);
    wb_xfer(1'b0, BASE, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_0717, "status_07");
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_0002, "count_2");

    // CTRL byte lanes
    wb_xfer(1'b1, BASE + 32'h8, 32'hABCD_1205, 4'b0010, 1'b1, 1'b0, 32'd0, "wr_hi");
    wb_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_1200, "ctrl_hi");
    wb_xfer(1'b1, BASE + 32'h8, 32'hFFFF_7702, 4'b0001, 1'b1, 1'b0, 32'd0, "wr_lo");
    wb_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_1202, "ctrl_lo");

    // T=4, pattern toggled every 3 cycles never commits
    pulse_reset();
    wb_xfer(1'b1, BASE + 32'h8, 32'h0000_0004, 4'h3, 1'b1, 1'b0, 32'd0, "wr_t4b");
    for (int i = 0; i < 8; i++) begin
      set_seg((i % 2 == 0) ? 7'h06 : 7'h00, e0);
      repeat (2) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    check_irq("toggle", 0, 0);
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_0000, "toggle_count");
    wb_xfer(1'b0, BASE + 32'hC, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_0000, "toggle_err");
    wb_xfer(1'b0, BASE, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_0000, "toggle_status");

    // T=2: valid 0x06, then invalid 0x49 keeps digit, bumps ERRCNT, no irq
    wb_xfer(1'b1, BASE + 32'h8, 32'h0000_0002, 4'h3, 1'b1, 1'b0, 32'd0, "wr_t2");
    set_seg(7'h06, e0);
    wait_edge(e0 + 8);
    check_irq("digit1", 1, e0 + 4);
    set_seg(7'h49, e1);
    wait_edge(e1 + 8);
    check_irq("invalid", 0, 0);
    wb_xfer(1'b0, BASE, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_4901, "status_49");
    wb_xfer(1'b0, BASE + 32'hC, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_0001, "errcnt_1");
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_0001, "count_1b");
    wb_xfer(1'b1, BASE + 32'hC, 32'h1234_5678, 4'h1, 1'b1, 1'b0, 32'd0, "err_clr");
    wb_xfer(1'b0, BASE + 32'hC, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_0000, "errcnt_clr");

    // Reset mid-count with a bus cycle in flight; re-presented pattern takes full T+3
    wb_xfer(1'b1, BASE + 32'h8, 32'h0000_0004, 4'h3, 1'b1, 1'b0, 32'd0, "wr_t4c");
    set_seg(7'h66, e0);
    wait_edge(e0 + 3);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h8; sel = 4'hF;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    check_outs_zero("rst_mid");
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    e1 = edge_n + 1;
    wait_edge(e1 + 1008);
    check_irq("after_rst", 1, e1 + 1002);
    wb_xfer(1'b0, BASE, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_6614, "status_66");
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_0001, "count_rst");
    wb_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_03E8, "ctrl_rst2");
    check32("sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
